// File: rtl/line_raster_stream.sv
// Streaming Bresenham line rasterizer: centre-origin segment in, LANES masked pixels per beat out.
// Optional macro CLIP_SKIP_EN: fully off-screen beats are advanced internally instead of presented.
module line_raster_stream #(
    parameter int COORD_W  = 13,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 19,
    parameter int LANES    = 2,
    parameter int COLOR_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COORD_W-1:0]         start_x,
    input  logic [COORD_W-1:0]         start_y,
    input  logic [COORD_W-1:0]         end_x,
    input  logic [COORD_W-1:0]         end_y,
    input  logic [COLOR_W-1:0]         color,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [LANES-1:0]           pix_mask,
    output logic [LANES*COORD_W-1:0]   pix_x,
    output logic [LANES*COORD_W-1:0]   pix_y,
    output logic [LANES*ADDR_W-1:0]    pix_addr,
    output logic [COLOR_W-1:0]         pix_color,
    output logic                       pix_last,
    output logic                       line_done
);

    localparam int W1 = COORD_W + 1;
    localparam int CW = COORD_W + 2;
    localparam logic signed [W1-1:0] HALF_W = W1'(SCREEN_W / 2);
    localparam logic signed [W1-1:0] HALF_H = W1'(SCREEN_H / 2);
    localparam logic signed [W1-1:0] SW_S   = W1'(SCREEN_W);
    localparam logic signed [W1-1:0] SH_S   = W1'(SCREEN_H);
    localparam logic signed [W1-1:0] ONE    = W1'(1);

    typedef enum logic [1:0] {IDLE, SETUP, EMIT, DONE} state_t;
    state_t state_reg, state_next;

    logic [COORD_W-1:0]     sx_in_reg, sy_in_reg, ex_in_reg, ey_in_reg;
    logic [COLOR_W-1:0]     color_reg;
    logic                   x_major_reg, maj_neg_reg, min_neg_reg;
    logic signed [W1-1:0]   d_maj_reg, d_min_reg, maj_reg, min_reg, err_reg;
    logic [CW-1:0]          cnt_reg, idx_reg;

    // Setup arithmetic: move to screen origin (y down) and classify the major axis.
    logic signed [W1-1:0] s_x, s_y, e_x, e_y, dif_x, dif_y, abs_x, abs_y, su_maj, su_min;
    logic                 su_xmaj;

    always_comb begin
        s_x     = {sx_in_reg[COORD_W-1], sx_in_reg} + HALF_W;
        s_y     = HALF_H - {sy_in_reg[COORD_W-1], sy_in_reg};
        e_x     = {ex_in_reg[COORD_W-1], ex_in_reg} + HALF_W;
        e_y     = HALF_H - {ey_in_reg[COORD_W-1], ey_in_reg};
        dif_x   = e_x - s_x;
        dif_y   = e_y - s_y;
        abs_x   = dif_x[W1-1] ? -dif_x : dif_x;
        abs_y   = dif_y[W1-1] ? -dif_y : dif_y;
        su_xmaj = (abs_x >= abs_y);
        su_maj  = su_xmaj ? abs_x : abs_y;
        su_min  = su_xmaj ? abs_y : abs_x;
    end

    // Lane i holds the generator state of the i-th pixel of the beat; entry LANES seeds the next beat.
    logic signed [W1-1:0] ln_maj [LANES+1];
    logic signed [W1-1:0] ln_min [LANES+1];
    logic signed [W1-1:0] ln_err [LANES+1];
    logic signed [W1-1:0] ln_tmp [LANES];

    always_comb begin
        ln_maj[0] = maj_reg;
        ln_min[0] = min_reg;
        ln_err[0] = err_reg;
        for (int i = 0; i < LANES; i++) begin
            ln_maj[i+1] = maj_neg_reg ? ln_maj[i] - ONE : ln_maj[i] + ONE;
            ln_tmp[i]   = ln_err[i] - d_min_reg;
            if (ln_tmp[i][W1-1]) begin
                ln_min[i+1] = min_neg_reg ? ln_min[i] - ONE : ln_min[i] + ONE;
                ln_err[i+1] = ln_tmp[i] + d_maj_reg;
            end else begin
                ln_min[i+1] = ln_min[i];
                ln_err[i+1] = ln_tmp[i];
            end
        end
    end

    logic             active, beat_last, advance;
    logic [LANES-1:0] lane_mask;

    assign active    = (state_reg == EMIT);
    assign beat_last = ((idx_reg + CW'(LANES)) >= cnt_reg);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [W1-1:0] lx, ly;
            logic                 in_count, on_screen;
            assign lx        = x_major_reg ? ln_maj[gi] : ln_min[gi];
            assign ly        = x_major_reg ? ln_min[gi] : ln_maj[gi];
            assign in_count  = ((idx_reg + CW'(gi)) < cnt_reg);
            assign on_screen = !lx[W1-1] && (lx < SW_S) && !ly[W1-1] && (ly < SH_S);
            assign lane_mask[gi] = active && in_count && on_screen;
            assign pix_x[gi*COORD_W +: COORD_W] = active ? lx[COORD_W-1:0] : '0;
            assign pix_y[gi*COORD_W +: COORD_W] = active ? ly[COORD_W-1:0] : '0;
            assign pix_addr[gi*ADDR_W +: ADDR_W] = lane_mask[gi]
                ? ADDR_W'($unsigned(ly)) * ADDR_W'(SCREEN_W) + ADDR_W'($unsigned(lx))
                : '0;
        end
    endgenerate

`ifdef CLIP_SKIP_EN
    assign pix_valid = active && (|lane_mask);
    assign advance   = active && (!pix_valid || pix_ready);
    assign pix_last  = pix_valid && beat_last;
`else
    assign pix_valid = active;
    assign advance   = active && pix_ready;
    assign pix_last  = active && beat_last;
`endif

    assign pix_mask  = lane_mask;
    assign pix_color = color_reg;
    assign in_ready  = (state_reg == IDLE);
    assign line_done = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SETUP;
            SETUP:   state_next = EMIT;
            EMIT:    if (advance && beat_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            sx_in_reg   <= '0;
            sy_in_reg   <= '0;
            ex_in_reg   <= '0;
            ey_in_reg   <= '0;
            color_reg   <= '0;
            x_major_reg <= 1'b0;
            maj_neg_reg <= 1'b0;
            min_neg_reg <= 1'b0;
            d_maj_reg   <= '0;
            d_min_reg   <= '0;
            maj_reg     <= '0;
            min_reg     <= '0;
            err_reg     <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                sx_in_reg <= start_x;
                sy_in_reg <= start_y;
                ex_in_reg <= end_x;
                ey_in_reg <= end_y;
                color_reg <= color;
            end
            if (state_reg == SETUP) begin
                x_major_reg <= su_xmaj;
                maj_neg_reg <= su_xmaj ? dif_x[W1-1] : dif_y[W1-1];
                min_neg_reg <= su_xmaj ? dif_y[W1-1] : dif_x[W1-1];
                d_maj_reg   <= su_maj;
                d_min_reg   <= su_min;
                maj_reg     <= su_xmaj ? s_x : s_y;
                min_reg     <= su_xmaj ? s_y : s_x;
                err_reg     <= su_maj >>> 1;
                cnt_reg     <= {1'b0, su_maj} + CW'(1);
                idx_reg     <= '0;
            end
            if (advance) begin
                maj_reg <= ln_maj[LANES];
                min_reg <= ln_min[LANES];
                err_reg <= ln_err[LANES];
                idx_reg <= idx_reg + CW'(LANES);
            end
        end
    end

endmodule

// File: tb/tb_line_raster_stream.sv
// Self-checking bench for line_raster_stream: directed table, backpressure, reset and random segments
// compared against a pixel-list reference model.
module tb_line_raster_stream;

    localparam int COORD_W  = 13;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;
    localparam int LANES    = 2;
    localparam int COLOR_W  = 4;
`ifdef CLIP_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                     clk, rst, in_valid, in_ready, pix_valid, pix_ready, pix_last, line_done;
    logic [COORD_W-1:0]       start_x, start_y, end_x, end_y;
    logic [COLOR_W-1:0]       color, pix_color;
    logic [LANES-1:0]         pix_mask;
    logic [LANES*COORD_W-1:0] pix_x, pix_y;
    logic [LANES*ADDR_W-1:0]  pix_addr;

    line_raster_stream #(
        .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
        .ADDR_W(ADDR_W), .LANES(LANES), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y), .color(color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_mask(pix_mask),
        .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr), .pix_color(pix_color),
        .pix_last(pix_last), .line_done(line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_x(input int i);
        return int'(pix_x[i*COORD_W +: COORD_W]);
    endfunction
    function automatic int lane_y(input int i);
        return int'(pix_y[i*COORD_W +: COORD_W]);
    endfunction
    function automatic int lane_a(input int i);
        return int'(pix_addr[i*ADDR_W +: ADDR_W]);
    endfunction

    int cap_x    [64][LANES];
    int cap_y    [64][LANES];
    int cap_addr [64][LANES];
    int cap_mask [64];
    int cap_last [64];

    // Drive one segment and check every accepted beat against the model.
    // bp: 0 = always ready, 1 = random ready, 2 = ready low for 5 cycles after the first beat.
    task automatic run_segment(input int ax, input int ay, input int bx, input int by,
                               input int col, input int bp, output int nacc, output int lastmask);
        int px[$], py[$], em[$], el[$], eb[$];
        int s_x, s_y, e_x, e_y, dx, dy, stx, sty, cx, cy, err, cnt, nb, m, idx;
        int n, k, hold, last_hs, first, budget;
        bit xmaj, done, pend;
        logic [LANES*COORD_W-1:0] snap_x, snap_y;
        logic [LANES*ADDR_W-1:0]  snap_a;
        logic [LANES-1:0]         snap_m;
        logic                     snap_l;

        s_x = ax + SCREEN_W / 2;  s_y = SCREEN_H / 2 - ay;
        e_x = bx + SCREEN_W / 2;  e_y = SCREEN_H / 2 - by;
        dx  = (e_x >= s_x) ? e_x - s_x : s_x - e_x;
        dy  = (e_y >= s_y) ? e_y - s_y : s_y - e_y;
        stx = (e_x >= s_x) ? 1 : -1;
        sty = (e_y >= s_y) ? 1 : -1;
        xmaj = (dx >= dy);
        cnt = (xmaj ? dx : dy) + 1;
        err = (xmaj ? dx : dy) / 2;
        cx = s_x; cy = s_y;
        for (int p = 0; p < cnt; p++) begin
            px.push_back(cx); py.push_back(cy);
            if (xmaj) begin
                cx += stx; err -= dy;
                if (err < 0) begin cy += sty; err += dx; end
            end else begin
                cy += sty; err -= dx;
                if (err < 0) begin cx += stx; err += dy; end
            end
        end
        nb = (cnt + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            m = 0;
            for (int i = 0; i < LANES; i++) begin
                idx = b * LANES + i;
                if (idx < cnt && px[idx] >= 0 && px[idx] < SCREEN_W && py[idx] >= 0 && py[idx] < SCREEN_H)
                    m |= (1 << i);
            end
            if (m != 0 || !SKIP) begin
                em.push_back(m); el.push_back(b == nb - 1); eb.push_back(b);
            end
        end

        @(negedge clk);
        start_x = COORD_W'(ax); start_y = COORD_W'(ay);
        end_x   = COORD_W'(bx); end_y   = COORD_W'(by);
        color   = COLOR_W'(col);
        in_valid = 1'b1;
        pix_ready = 1'b1;
        check("in_ready_idle", in_ready, 1);

        n = 0; k = 0; hold = 0; last_hs = -1; first = -1; done = 0; pend = 0;
        lastmask = 0;
        budget = 20 * nb + 50;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1) in_valid = 1'b0;
            if (nb >= 3 && n == 3) begin
                // A request while busy must be ignored.
                start_x = COORD_W'(17); end_x = COORD_W'(-99); in_valid = 1'b1;
            end
            if (nb >= 3 && n == 4) in_valid = 1'b0;
            case (bp)
                1:       pix_ready = ($urandom_range(0, 3) != 0);
                2:       pix_ready = !(k >= 1 && hold < 5);
                default: pix_ready = 1'b1;
            endcase
            if (bp == 2 && !pix_ready) hold++;
            if (pend) begin
                check("stall_x", pix_x, snap_x);
                check("stall_y", pix_y, snap_y);
                check("stall_addr", pix_addr, snap_a);
                check("stall_mask", pix_mask, snap_m);
                check("stall_last", pix_last, snap_l);
                check("stall_valid", pix_valid, 1);
                pend = 0;
            end
            if (line_done) begin
                check("beats_at_done", k, em.size());
                check("valid_in_done", pix_valid, 0);
                if (em.size() > 0 && el[em.size()-1] == 1)
                    check("done_after_last", n, last_hs + 1);
                done = 1;
            end else begin
                check("in_ready_busy", in_ready, 0);
                if (pix_valid) begin
                    if (first < 0) begin
                        first = n;
                        if (em.size() > 0 && eb[0] == 0) check("first_valid_latency", n, 2);
                    end
                    if (pix_ready) begin
                        if (k >= em.size()) begin
                            check("extra_beat", k, em.size());
                        end else begin
                            check("mask", pix_mask, em[k]);
                            check("last", pix_last, el[k]);
                            check("color", pix_color, col & ((1 << COLOR_W) - 1));
                            for (int i = 0; i < LANES; i++) begin
                                if (em[k][i]) begin
                                    idx = eb[k] * LANES + i;
                                    check("x", lane_x(i), px[idx]);
                                    check("y", lane_y(i), py[idx]);
                                    check("addr", lane_a(i), py[idx] * SCREEN_W + px[idx]);
                                end
                            end
                        end
                        if (k < 64) begin
                            for (int i = 0; i < LANES; i++) begin
                                cap_x[k][i] = lane_x(i); cap_y[k][i] = lane_y(i); cap_addr[k][i] = lane_a(i);
                            end
                            cap_mask[k] = int'(pix_mask);
                            cap_last[k] = int'(pix_last);
                        end
                        lastmask = int'(pix_mask);
                        k++;
                        last_hs = n;
                    end else begin
                        snap_x = pix_x; snap_y = pix_y; snap_a = pix_addr;
                        snap_m = pix_mask; snap_l = pix_last; pend = 1;
                    end
                end
            end
        end
        in_valid = 1'b0;
        if (!done) check("line_done_timeout", n, -1);
        @(negedge clk);
        check("done_pulse_width", line_done, 0);
        check("in_ready_after", in_ready, 1);
        nacc = k;
    endtask

    typedef struct {
        int sx, sy, ex, ey;
        int beats, skip_beats, last_mask;
    } vec_t;

    vec_t vecs [7];
    int nacc, lm, cidx;

    initial begin
        rst = 1'b1; in_valid = 1'b0; pix_ready = 1'b0;
        start_x = '0; start_y = '0; end_x = '0; end_y = '0; color = '0;

        vecs[0] = '{0, 0, 3, 0, 2, 2, 3};
        vecs[1] = '{0, 0, 2, 2, 2, 2, 1};
        vecs[2] = '{0, 0, 4, 1, 3, 3, 1};
        vecs[3] = '{-400, 0, -318, 0, 42, 2, 1};
        vecs[4] = '{0, 0, 0, 0, 1, 1, 1};
        vecs[5] = '{319, -239, 330, -250, 6, 1, 0};
        vecs[6] = '{-320, 240, -321, 241, 1, 1, 1};

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", pix_valid, 0);
        check("rst_mask", pix_mask, 0);
        check("rst_last", pix_last, 0);
        check("rst_done", line_done, 0);
        check("rst_addr", pix_addr, 0);
        check("rst_x", pix_x, 0);
        check("rst_color", pix_color, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_segment(vecs[t].sx, vecs[t].sy, vecs[t].ex, vecs[t].ey, t + 3, 0, nacc, lm);
            check("tbl_beats", nacc, SKIP ? vecs[t].skip_beats : vecs[t].beats);
            if (!SKIP) check("tbl_last_mask", lm, vecs[t].last_mask);
            $display("vector %0d: (%0d,%0d)->(%0d,%0d) beats=%0d last_mask=%0d",
                     t, vecs[t].sx, vecs[t].sy, vecs[t].ex, vecs[t].ey, nacc, lm);
            if (t == 0) begin
                check("t0_addr00", cap_addr[0][0], 153920);
                check("t0_addr01", cap_addr[0][1], 153921);
                check("t0_addr10", cap_addr[1][0], 153922);
                check("t0_addr11", cap_addr[1][1], 153923);
                check("t0_last0", cap_last[0], 0);
                check("t0_last1", cap_last[1], 1);
            end
            if (t == 1) begin
                check("t1_x01", cap_x[0][1], 321);
                check("t1_y01", cap_y[0][1], 239);
                check("t1_addr01", cap_addr[0][1], 153281);
                check("t1_x10", cap_x[1][0], 322);
                check("t1_y10", cap_y[1][0], 238);
                check("t1_mask1", cap_mask[1], 1);
            end
            if (t == 2) begin
                check("t2_y0", cap_y[0][0], 240);
                check("t2_y1", cap_y[0][1], 240);
                check("t2_y2", cap_y[1][0], 240);
                check("t2_y3", cap_y[1][1], 239);
                check("t2_y4", cap_y[2][0], 239);
            end
            if (t == 3) begin
                cidx = SKIP ? 0 : 40;
                check("clip_mask_a", cap_mask[cidx], 3);
                check("clip_x_a0", cap_x[cidx][0], 0);
                check("clip_x_a1", cap_x[cidx][1], 1);
                check("clip_mask_b", cap_mask[cidx+1], 1);
                check("clip_x_b0", cap_x[cidx+1][0], 2);
                check("clip_last_b", cap_last[cidx+1], 1);
            end
        end

        run_segment(0, 0, 3, 0, 9, 2, nacc, lm);
        check("bp_beats", nacc, 2);
        check("bp_addr11", cap_addr[1][1], 153923);
        $display("backpressure: beats=%0d", nacc);

        // Reset in the middle of the second beat.
        @(negedge clk);
        start_x = '0; start_y = '0; end_x = COORD_W'(3); end_y = '0; color = 4'd7;
        in_valid = 1'b1; pix_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", pix_valid, 1);
        @(negedge clk);
        check("pre_rst_addr", lane_a(0), 153922);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_mask", pix_mask, 0);
        check("mid_rst_last", pix_last, 0);
        check("mid_rst_done", line_done, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_addr", pix_addr, 0);
        check("mid_rst_y", pix_y, 0);
        check("mid_rst_color", pix_color, 0);
        $display("reset mid-segment: valid=%0d in_ready=%0d", pix_valid, in_ready);
        @(negedge clk);
        rst = 1'b0;
        run_segment(0, 0, 2, 2, 5, 0, nacc, lm);
        check("post_rst_beats", nacc, 2);

        for (int r = 0; r < 30; r++) begin
            int ax, ay, bx, by;
            ax = int'($urandom_range(0, 700)) - 350;
            ay = int'($urandom_range(0, 520)) - 260;
            bx = int'($urandom_range(0, 700)) - 350;
            by = int'($urandom_range(0, 520)) - 260;
            run_segment(ax, ay, bx, by, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), nacc, lm);
            $display("random %0d: (%0d,%0d)->(%0d,%0d) beats=%0d", r, ax, ay, bx, by, nacc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
